alu_flag_wb: RTL and testbench

//  Stage directly downstream of the combinational ALU. Owns the carry (sc) and parity flag

---
 rtl/alu_flag_wb.sv | 94 +++++++++
 tb/tb_alu_flag_wb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_wb.sv
// ALU writeback stage: owns the carry/parity flags fed back to the ALU and
// buffers results in a 2-entry FIFO toward register-file writeback.
module alu_flag_wb #(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_we,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] rslt,
    input  logic          sc_o,
    input  logic          sc_en,
    input  logic          sc_clr,
    input  logic          pari,
    input  logic          pari_en,
    input  logic          pari_clr,
    input  logic          flush,
    output logic          sc_q,
    output logic          pari_q,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic          wb_we,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic [15:0]   ops_cnt
);

    logic [1:0]    cnt;
    logic          wp;
    logic          rp;
    logic          mem_we   [2];
    logic [RW-1:0] mem_rd   [2];
    logic [DW-1:0] mem_data [2];
    logic          push;
    logic          pop;

    // Full is judged on the registered count only; no same-cycle pop bypass.
    assign in_ready = ~cnt[1] & ~flush;
    assign push     = in_valid & in_ready;
    assign pop      = wb_valid & wb_ready & ~flush;

    assign wb_valid = (cnt != 2'd0);
    assign wb_we    = mem_we[rp];
    assign wb_rd    = mem_rd[rp];
    assign wb_data  = mem_data[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 2'd0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            sc_q    <= 1'b0;
            pari_q  <= 1'b0;
            ops_cnt <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                mem_we[i]   <= 1'b0;
                mem_rd[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else if (flush) begin
            cnt <= 2'd0;
            wp  <= 1'b0;
            rp  <= 1'b0;
        end else begin
            if (push) begin
                mem_we[wp]   <= in_we;
                mem_rd[wp]   <= in_rd;
                mem_data[wp] <= rslt;
                wp           <= ~wp;
                ops_cnt      <= ops_cnt + 16'd1;
                // Clear beats enable for carry; enable beats clear for parity.
                if (sc_clr)
                    sc_q <= 1'b0;
                else if (sc_en)
                    sc_q <= sc_o;
                if (pari_en)
                    pari_q <= pari;
                else if (pari_clr)
                    pari_q <= 1'b0;
            end
            if (pop)
                rp <= ~rp;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_wb.sv
// Scoreboard bench for alu_flag_wb: directed beats push expectations,
// an independent monitor retires them against the writeback port.
module tb_alu_flag_wb;

    typedef struct packed {
        logic       we;
        logic [2:0] rd;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_we = 1'b0;
    logic [2:0] in_rd = '0;
    logic [7:0] rslt = '0;
    logic       sc_o = 1'b0;
    logic       sc_en = 1'b0;
    logic       sc_clr = 1'b0;
    logic       pari = 1'b0;
    logic       pari_en = 1'b0;
    logic       pari_clr = 1'b0;
    logic       flush = 1'b0;
    logic       sc_q;
    logic       pari_q;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic       wb_we;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [15:0] ops_cnt;

    int    checks = 0;
    int    errors = 0;
    ent_t  sb[$];
    logic [15:0] exp_ops = 16'd0;
    logic  acc;
    logic  sv_sc;
    logic  sv_pa;

    alu_flag_wb #(.DW(8), .RW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_we(in_we), .in_rd(in_rd), .rslt(rslt),
        .sc_o(sc_o), .sc_en(sc_en), .sc_clr(sc_clr),
        .pari(pari), .pari_en(pari_en), .pari_clr(pari_clr),
        .flush(flush), .sc_q(sc_q), .pari_q(pari_q),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ops_cnt(ops_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fl = {sc_o, sc_en, sc_clr, pari, pari_en, pari_clr}
    task automatic beat(input logic we, input logic [2:0] rd,
                        input logic [7:0] d, input logic [5:0] fl);
        in_valid = 1'b1;
        in_we    = we;
        in_rd    = rd;
        rslt     = d;
        {sc_o, sc_en, sc_clr, pari, pari_en, pari_clr} = fl;
        @(negedge clk);
        acc = in_valid & in_ready;
        if (acc) begin
            sb.push_back('{we: we, rd: rd, data: d});
            exp_ops = exp_ops + 16'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {sc_o, sc_en, sc_clr, pari, pari_en, pari_clr} = 6'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        wb_ready = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush && wb_valid && wb_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got %0h expected none",
                             {wb_we, wb_rd, wb_data});
                end else begin
                    e = sb.pop_front();
                    if ({wb_we, wb_rd, wb_data} !== e) begin
                        errors++;
                        $display("FAIL wb_entry: got %0h expected %0h",
                                 {wb_we, wb_rd, wb_data}, e);
                    end
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_sc", sc_q, 0);
        chk("rst_pari", pari_q, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_ops", ops_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // ADD beat with carry load
        wb_ready = 1'b1;
        beat(1'b1, 3'd3, 8'h5A, 6'b110000);
        chk("add_sc", sc_q, 1);
        chk("add_valid", wb_valid, 1);
        chk("add_rd", wb_rd, 3);
        chk("add_data", wb_data, 8'h5A);
        chk("add_ops", ops_cnt, exp_ops);

        // clear wins for carry, enable wins for parity
        beat(1'b0, 3'd1, 8'h0F, 6'b111111);
        chk("pri_sc", sc_q, 0);
        chk("pri_pari", pari_q, 1);
        beat(1'b1, 3'd2, 8'h10, 6'b110001);
        chk("clr_pari", pari_q, 0);
        chk("ld_sc", sc_q, 1);

        // controls without in_valid must not touch flags
        sc_clr = 1'b1;
        pari_en = 1'b1;
        pari = 1'b1;
        @(posedge clk);
        #1;
        sc_clr = 1'b0;
        pari_en = 1'b0;
        pari = 1'b0;
        chk("idle_sc", sc_q, 1);
        chk("idle_pari", pari_q, 0);
        drain();

        // back-pressure: full blocks third beat, order preserved
        wb_ready = 1'b0;
        beat(1'b1, 3'd4, 8'h11, 6'b0);
        beat(1'b0, 3'd5, 8'h22, 6'b0);
        chk("full_ready", in_ready, 0);
        beat(1'b1, 3'd6, 8'h99, 6'b0);
        chk("full_not_taken", acc, 0);
        chk("full_hold", wb_data, 8'h11);
        chk("full_ops", ops_cnt, exp_ops);
        drain();

        // simultaneous push and pop at count 1
        wb_ready = 1'b0;
        beat(1'b1, 3'd1, 8'h44, 6'b0);
        wb_ready = 1'b1;
        beat(1'b1, 3'd7, 8'h33, 6'b0);
        wb_ready = 1'b0;
        chk("pp_valid", wb_valid, 1);
        chk("pp_head", wb_data, 8'h33);
        chk("pp_ready", in_ready, 1);
        chk("pp_ops", ops_cnt, exp_ops);
        drain();

        // flush with two buffered beats and a competing beat
        wb_ready = 1'b0;
        beat(1'b1, 3'd2, 8'hA1, 6'b110000);
        beat(1'b1, 3'd3, 8'hA2, 6'b000110);
        sv_sc = sc_q;
        sv_pa = pari_q;
        chk("pre_fl_sc", sv_sc, 1);
        flush = 1'b1;
        wb_ready = 1'b1;
        in_valid = 1'b1;
        sc_clr = 1'b1;
        rslt = 8'hEE;
        @(negedge clk);
        chk("fl_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sc_clr = 1'b0;
        chk("fl_valid", wb_valid, 0);
        chk("fl_sc", sc_q, sv_sc);
        chk("fl_pari", pari_q, sv_pa);
        chk("fl_ops", ops_cnt, exp_ops);
        beat(1'b1, 3'd5, 8'h55, 6'b0);
        chk("post_fl_data", wb_data, 8'h55);
        drain();

        // asynchronous reset mid-stream
        wb_ready = 1'b0;
        beat(1'b1, 3'd1, 8'hB1, 6'b110000);
        beat(1'b1, 3'd2, 8'hB2, 6'b0);
        chk("pre_rst_sc", sc_q, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_ops = 16'd0;
        #1;
        chk("mrst_valid", wb_valid, 0);
        chk("mrst_sc", sc_q, 0);
        chk("mrst_ops", ops_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ops_cnt wrap with continuous streaming
        wb_ready = 1'b1;
        for (int i = 0; i < 65535; i++)
            beat(1'b1, i[2:0], i[7:0], 6'b0);
        chk("ops_ffff", ops_cnt, 16'hFFFF);
        beat(1'b0, 3'd0, 8'hC3, 6'b0);
        chk("ops_wrap", ops_cnt, 16'h0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
